mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported RAM between the instruction cache and the data cache
//  of one core. Grants one requester at a time and drives the RAM port from it.
//  Returns that requester's wait/load handshake. Data side has priority; a
//  starvation counter bounds instruction-side delay. Sits between the caches and RAM.
// PARAMETERS
//  STARVE_MAX  4  consecutive D grants with I pending before I is forced (1..15)
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   synchronous reset, active-high
//  iREN      in   1   icache read request
//  iaddr     in   32  icache word address
//  iwait     out  1   0 = iload valid this cycle (one-cycle completion pulse)
//  iload     out  32  read data to icache (= ramload)
//  dREN      in   1   dcache read request
//  dWEN      in   1   dcache write request (wins over dREN if both set)
//  daddr     in   32  dcache word address
//  dstore    in   32  dcache write data
//  dwait     out  1   0 = D access complete this cycle
//  dload     out  32  read data to dcache (= ramload)
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
//  err       out  1   sticky: RAM returned ERROR since reset
// BEHAVIOUR
//  - Reset (RST high at edge): state=IDLE, starve_cnt=0, err=0; with state IDLE,
//    outputs are iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0.
//  - FSM states: IDLE, GRANT_I, GRANT_D (registered); RAM outputs are
//    combinational from the state and the granted requester's live inputs.
//  - IDLE: no RAM enables, both waits 1. Next state:
//      I pending and starve_cnt==STARVE_MAX -> GRANT_I.
//      else D pending (dREN|dWEN) -> GRANT_D.
//      else iREN -> GRANT_I.
//      else stay.
//  - GRANT_I: ramREN=1, ramaddr=iaddr.
//  - GRANT_D: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
//  - In a GRANT state with ramstate==ACCESS: that requester's wait=0 for exactly
//    this cycle. Next state is IDLE. The other wait stays 1.
//  - ramstate FREE/BUSY: hold the grant, waits stay 1.
//  - ramstate ERROR: waits stay 1, err<=1, next state IDLE; requester re-arbitrates.
//  - Requester drops its request while granted: next state IDLE, no wait pulse.
//    No RAM enable is driven in that cycle.
//  - Min latency: request to wait=0 is 2 cycles (IDLE->GRANT, RAM ACCESS same cycle).
//  - starve_cnt (4b): +1 on each IDLE->GRANT_D while iREN=1, saturating at STARVE_MAX.
//    Cleared on IDLE->GRANT_I or when iREN=0 in IDLE.
//  - iload=dload=ramload always; only the wait pulse qualifies them.
//  - RST mid-access: abandon the transfer, return to reset values next cycle;
//    no completion pulse.
// STRUCTURE
//  - ramstate_t (FREE=0,BUSY=1,ACCESS=2,ERROR=3) and word_t in cpu_types_pkg.
//  - arb_state_t enum local to module.
//  - One sub-module: arb_starve_ctr (saturating counter: inc, clr, sat out).
// TESTING
//  - Reset: RST=1 two cycles -> iwait=dwait=1, ramREN=ramWEN=0, err=0.
//  - Lone I read of 0x40; RAM BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF
//    -> ramaddr=0x40, iwait=0 one cycle, iload=0xDEADBEEF.
//  - iREN and dWEN both rise together (daddr=0x80, dstore=0x1234) -> D granted first.
//    ramWEN=1, ramstore=0x1234; after dwait pulse, I granted on the next grant.
//  - STARVE_MAX=4, dREN held continuously with iREN held -> 4 D completions,
//    then GRANT_I, then D resumes.
//  - ramstate=ERROR during D access -> dwait stays 1, err=1 and sticky, FSM to IDLE.
//    D then re-granted.
//  - iREN dropped while GRANT_I with RAM BUSY -> IDLE next cycle, iwait never 0.
//    RST asserted mid GRANT_D -> all outputs at reset values.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive data-side grants taken while the
// instruction side was waiting. o_sat forces the next grant to the icache.
import cpu_types_pkg::*;

module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] r_cnt;

  // Count up on request, hold at MAX; clear wins over increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between icache and dcache. Data side has
// priority; a starvation counter bounds how long the icache can be held off.
//
// state   | meaning
// IDLE    | no grant, RAM enables low, arbitrate for next cycle
// GRANT_I | icache owns the RAM port until ACCESS, ERROR or request drop
// GRANT_D | dcache owns the RAM port until ACCESS, ERROR or request drop
import cpu_types_pkg::*;

module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_err;
  logic       w_err_set;
  logic       w_inc;
  logic       w_clr;
  logic       w_sat;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_sat (w_sat)
  );

  // State and sticky error registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Arbitration, RAM port mux and wait pulses; a dropped request releases
  // the grant without touching the RAM.
  always_comb begin
    w_next    = r_state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    w_inc     = 1'b0;
    w_clr     = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (iREN && w_sat) begin
          w_next = GRANT_I;
          w_clr  = 1'b1;
        end else if (dREN || dWEN) begin
          w_next = GRANT_D;
          w_inc  = iREN;
          w_clr  = ~iREN;
        end else if (iREN) begin
          w_next = GRANT_I;
          w_clr  = 1'b1;
        end else begin
          w_clr  = 1'b1;
        end
      end
      GRANT_I: begin
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait  = 1'b0;
            w_next = IDLE;
          end else if (ramstate == ERROR) begin
            w_err_set = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      GRANT_D: begin
        if (!(dREN || dWEN)) begin
          w_next = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == ACCESS) begin
            dwait  = 1'b0;
            w_next = IDLE;
          end else if (ramstate == ERROR) begin
            w_err_set = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
  assign err   = r_err;

endmodule
